nvdla_rubik_rd_req_gen: RTL and testbench
=========================================

// Module: nvdla_rubik_rd_req_gen
// PURPOSE
// - Rubik read-request generator: walks a surface (base, line stride, width in 32B atoms, height) and issues DMA read requests of 1 or 2 atoms each.
// - Sits directly upstream of the Rubik read-response path. Each request yields exactly one 514b response beat: mask[1:0] plus 512b data.
// - Flow control is a latency-FIFO credit counter, so responses never overrun the response FIFOs.
// - Credits return on rd_cdt_lat_fifo_pop from the response stage.
// PARAMETERS
// - ADDR_W      64   DMA byte-address width.
// - LAT_DEPTH   64   latency-FIFO entries = credit pool size, >=1.
// - WIDTH_W     13   width of cfg_width (atoms per line).
// - HEIGHT_W    13   width of cfg_height (lines).
// PORTS
// - nvdla_core_clk     in   1        core clock.
// - nvdla_core_rst     in   1        synchronous reset, active-high.
// - op_en              in   1        start pulse. Ignored unless state==IDLE.
// - cfg_base_addr      in   ADDR_W   surface base, 32B aligned (bits[4:0] ignored).
// - cfg_line_stride    in   32       bytes between line starts, 32B aligned.
// - cfg_width          in   WIDTH_W  atoms per line minus 1.
// - cfg_height         in   HEIGHT_W lines minus 1.
// - dma_rd_req_vld     out  1        request valid.
// - dma_rd_req_rdy     in   1        request ready.
// - dma_rd_req_pd      out  ADDR_W+15 {size[14:0] = atoms-1 (0 or 1), addr[ADDR_W-1:0]}.
// - rd_cdt_lat_fifo_pop in  1        one credit returned per cycle high.
// - op_busy            out  1        high from op_en accept until op_done.
// - op_done            out  1        one-cycle pulse after the last credit returns.
// - perf_req_stall     out  32       cycles with vld & !rdy.
// - perf_cdt_stall     out  32       cycles in REQ with credits==0.
// BEHAVIOUR
// - Reset values: state=IDLE, credits=LAT_DEPTH, all outputs 0, pd=0.
// - Config is latched on op_en accept. Later cfg changes have no effect mid-op.
// - FSM states: IDLE -> REQ on op_en.
//   - REQ -> DRAIN when the last request of the last line is accepted.
//   - DRAIN -> DONE when credits==LAT_DEPTH.
//   - DONE -> IDLE after 1 cycle; op_done=1 during DONE only.
// - Request split per line, with addr = current atom address:
//   - size=1 (2 atoms) if addr[5]==0 and remaining atoms >=2.
//   - Otherwise size=0 (1 atom).
//   - Unaligned line start therefore yields a leading single. Odd remainder yields a trailing single.
// - After the last atom of a line: line_addr += cfg_line_stride, atom addr = new line_addr.
//   - Address adds wrap modulo 2^ADDR_W, no error.
// - dma_rd_req_vld = (state==REQ) & (credits!=0). Output is combinational from registered address, credit and state.
// - Once vld is asserted, pd is held stable until accepted. Credits only decrease on accept, so vld cannot drop early.
// - Credits: decrement on vld&rdy, increment on pop. Both in the same cycle leaves credits unchanged.
// - Pop with credits==LAT_DEPTH is illegal: assertion fires and credits saturate at LAT_DEPTH.
// - Latency: the first request is valid on the cycle after op_en.
//   - Thereafter one request is accepted per cycle when rdy=1 and credits>0.
// - Reset mid-operation returns the block to IDLE with full credits. Upstream and downstream are reset together.
// CONFIGURATION
// - Macro RUBIK_RD_REQ_PERF_EN.
// - When defined, perf_req_stall and perf_cdt_stall are saturating counters. They clear on op_en accept and hold after op_done.
// - When undefined, both outputs are tied to 0 and no counter flops are built. The port list is identical either way.
// STRUCTURE
// - Package nvdla_rubik_rd_pkg holds:
//   - state enum {IDLE, REQ, DRAIN, DONE};
//   - request pd field offsets (ADDR_LSB=0, SIZE_LSB=ADDR_W);
//   - ATOM_BYTES=32 and SIZE_1ATOM/SIZE_2ATOM constants.
// - Sub-module nvdla_rubik_rd_cdt_cnt: credit counter (LAT_DEPTH) with inputs take/give and outputs credits and empty/full.
// - Top module: FSM, address/atom/line counters, perf counters.
// TESTING
// - T1 aligned: base=0x1000, width=3 (4 atoms), height=1 (2 lines), stride=0x200, rdy=1, pop 4 cycles after each accept.
//   - Expect 4 reqs: 0x1000/s1, 0x1040/s1, 0x1200/s1, 0x1240/s1, then op_done.
// - T2 unaligned: base=0x1020, width=3, height=0.
//   - Expect 0x1020/s0, 0x1040/s1, 0x1080/s0.
// - T3 credits: LAT_DEPTH=4, width=15, height=0, no pops.
//   - Expect exactly 4 accepts, then vld=0. One pop gives one more accept.
//   - With RUBIK_RD_REQ_PERF_EN, perf_cdt_stall grows each stalled cycle.
// - T4 backpressure: rdy=0 for 10 cycles with vld high.
//   - Expect pd stable throughout and perf_req_stall=10 (macro on) or 0 (macro off).
// - T5 simultaneous: accept and pop in the same cycle with credits=2.
//   - Expect credits stays 2. op_done only after all pops return credits to LAT_DEPTH.
// - T6 reset: assert nvdla_core_rst mid-REQ.
//   - Next cycle: vld=0, op_busy=0, credits=LAT_DEPTH. A new op_en restarts from cfg_base_addr.

Source files
------------

// File: rtl/nvdla_rubik_rd_req_gen_pkg.sv
// Shared types and constants for the Rubik read-request generator.
package nvdla_rubik_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int ATOM_BYTES = 32;
    localparam int ATOM_SHIFT = 5;

    // Request pd layout: {size, addr}; size counts atoms minus one.
    localparam int SIZE_W   = 15;
    localparam int ADDR_LSB = 0;
    localparam logic [SIZE_W-1:0] SIZE_1ATOM = 15'd0;
    localparam logic [SIZE_W-1:0] SIZE_2ATOM = 15'd1;

    function automatic int size_lsb(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/nvdla_rubik_rd_req_gen_if.sv
// DMA read-request channel: valid/ready handshake plus {size, addr} payload.
interface nvdla_rubik_rd_req_gen_if #(
    parameter int ADDR_W = 64
);
    logic                                     dma_rd_req_vld;
    logic                                     dma_rd_req_rdy;
    logic [ADDR_W+nvdla_rubik_rd_pkg::SIZE_W-1:0] dma_rd_req_pd;

    modport master (
        output dma_rd_req_vld,
        output dma_rd_req_pd,
        input  dma_rd_req_rdy
    );

    modport slave (
        input  dma_rd_req_vld,
        input  dma_rd_req_pd,
        output dma_rd_req_rdy
    );
endinterface

// File: rtl/nvdla_rubik_rd_req_gen_cdt_cnt.sv
// Latency-FIFO credit pool: take on request accept, give on response pop.
// Registered count, no added latency; a give at full saturates and is flagged.
module nvdla_rubik_rd_cdt_cnt #(
    parameter int LAT_DEPTH = 64,
    parameter int CNT_W     = $clog2(LAT_DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             take,
    input  logic             give,
    output logic [CNT_W-1:0] credits,
    output logic             empty,
    output logic             full
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            credits <= CNT_MAX;
        end else if (take && !give) begin
            credits <= credits - CNT_ONE;
        end else if (give && !take && !full) begin
            credits <= credits + CNT_ONE;
        end
    end

    assign empty = (credits == '0);
    assign full  = (credits == CNT_MAX);

    // A pop with every credit already home means the response side is out of sync.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rst && give && !take) begin
            assert (!full);
        end
    end

endmodule

// File: rtl/nvdla_rubik_rd_req_gen.sv
// Rubik read-request generator: walks a surface line by line issuing 1- or 2-atom DMA reads.
// Latency: first request valid the cycle after op_en; then one accept per cycle while rdy and credits allow.
// Backpressure: pd held until accepted; vld drops only when credits run out. Perf counters under RUBIK_RD_REQ_PERF_EN.
module nvdla_rubik_rd_req_gen
    import nvdla_rubik_rd_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int LAT_DEPTH = 64,
    parameter int WIDTH_W   = 13,
    parameter int HEIGHT_W  = 13
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    op_en,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [31:0]             cfg_line_stride,
    input  logic [WIDTH_W-1:0]      cfg_width,
    input  logic [HEIGHT_W-1:0]     cfg_height,
    nvdla_rubik_rd_req_gen_if.master dma,
    input  logic                    rd_cdt_lat_fifo_pop,
    output logic                    op_busy,
    output logic                    op_done,
    output logic [31:0]             perf_req_stall,
    output logic [31:0]             perf_cdt_stall
);
    localparam int CNT_W    = $clog2(LAT_DEPTH + 1);
    localparam int SIZE_LSB = size_lsb(ADDR_W);
    localparam logic [WIDTH_W:0]    ATOMS_ONE = (WIDTH_W+1)'(1);
    localparam logic [WIDTH_W:0]    ATOMS_TWO = (WIDTH_W+1)'(2);
    localparam logic [HEIGHT_W-1:0] LINE_ONE  = HEIGHT_W'(1);

    rd_state_e             state;
    logic [ADDR_W-1:0]     line_addr;
    logic [ADDR_W-1:0]     atom_addr;
    logic [WIDTH_W:0]      atoms_left;
    logic [WIDTH_W-1:0]    width_q;
    logic [HEIGHT_W-1:0]   lines_left;
    logic [31:0]           stride_q;

    logic [CNT_W-1:0]      credits;
    logic                  cdt_empty;
    logic                  cdt_full;

    logic                  req_vld;
    logic                  accept;
    logic                  pair_ok;
    logic                  line_end;
    logic [SIZE_W-1:0]     req_size;
    logic [WIDTH_W:0]      req_step;
    logic [ADDR_W-1:0]     atom_inc;
    logic [ADDR_W-1:0]     next_line_addr;
    logic [ADDR_W-1:0]     base_al;
    logic [31:0]           stride_al;
    logic [ADDR_W+SIZE_W-1:0] req_pd;

    nvdla_rubik_rd_cdt_cnt #(
        .LAT_DEPTH (LAT_DEPTH),
        .CNT_W     (CNT_W)
    ) u_cdt (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .take           (accept),
        .give           (rd_cdt_lat_fifo_pop),
        .credits        (credits),
        .empty          (cdt_empty),
        .full           (cdt_full)
    );

    assign base_al   = cfg_base_addr & ~ADDR_W'(ATOM_BYTES - 1);
    assign stride_al = cfg_line_stride & ~32'(ATOM_BYTES - 1);

    // A pair must start on a 64B boundary so it never straddles one.
    assign pair_ok        = !atom_addr[ATOM_SHIFT] && (atoms_left >= ATOMS_TWO);
    assign req_size       = pair_ok ? SIZE_2ATOM : SIZE_1ATOM;
    assign req_step       = pair_ok ? ATOMS_TWO : ATOMS_ONE;
    assign atom_inc       = pair_ok ? ADDR_W'(2 * ATOM_BYTES) : ADDR_W'(ATOM_BYTES);
    assign line_end       = (atoms_left == req_step);
    assign next_line_addr = line_addr + ADDR_W'(stride_q);

    assign req_vld = (state == REQ) && !cdt_empty;
    assign accept  = req_vld && dma.dma_rd_req_rdy;

    always_comb begin
        req_pd = '0;
        req_pd[ADDR_LSB +: ADDR_W] = atom_addr;
        req_pd[SIZE_LSB +: SIZE_W] = req_size;
    end

    assign dma.dma_rd_req_vld = req_vld;
    assign dma.dma_rd_req_pd  = req_pd;
    assign op_busy            = (state != IDLE);
    assign op_done            = (state == DONE);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state      <= IDLE;
            line_addr  <= '0;
            atom_addr  <= '0;
            atoms_left <= '0;
            width_q    <= '0;
            lines_left <= '0;
            stride_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_en) begin
                        line_addr  <= base_al;
                        atom_addr  <= base_al;
                        width_q    <= cfg_width;
                        atoms_left <= {1'b0, cfg_width} + ATOMS_ONE;
                        lines_left <= cfg_height;
                        stride_q   <= stride_al;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (accept) begin
                        if (!line_end) begin
                            atom_addr  <= atom_addr + atom_inc;
                            atoms_left <= atoms_left - req_step;
                        end else if (lines_left == '0) begin
                            state <= DRAIN;
                        end else begin
                            line_addr  <= next_line_addr;
                            atom_addr  <= next_line_addr;
                            atoms_left <= {1'b0, width_q} + ATOMS_ONE;
                            lines_left <= lines_left - LINE_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (cdt_full) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rst) begin
            assert (credits <= CNT_W'(LAT_DEPTH));
        end
    end

`ifdef RUBIK_RD_REQ_PERF_EN
    logic [31:0] req_stall_cnt;
    logic [31:0] cdt_stall_cnt;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            req_stall_cnt <= '0;
            cdt_stall_cnt <= '0;
        end else if ((state == IDLE) && op_en) begin
            req_stall_cnt <= '0;
            cdt_stall_cnt <= '0;
        end else begin
            if (req_vld && !dma.dma_rd_req_rdy && (req_stall_cnt != '1)) begin
                req_stall_cnt <= req_stall_cnt + 32'd1;
            end
            if ((state == REQ) && cdt_empty && (cdt_stall_cnt != '1)) begin
                cdt_stall_cnt <= cdt_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_req_stall = req_stall_cnt;
    assign perf_cdt_stall = cdt_stall_cnt;
`else
    assign perf_req_stall = '0;
    assign perf_cdt_stall = '0;
`endif

endmodule

// File: tb/tb_nvdla_rubik_rd_req_gen.sv
// Bench for nvdla_rubik_rd_req_gen: directed table, multi-cycle corner sequences, randomized ops vs a request-list model.
module tb_nvdla_rubik_rd_req_gen;
    localparam int ADDR_W   = 64;
    localparam int LAT      = 4;
    localparam int WIDTH_W  = 13;
    localparam int HEIGHT_W = 13;
    localparam int NVEC     = 6;
    localparam int BUDGET   = 3000;
`ifdef RUBIK_RD_REQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct {
        logic [63:0] addr;
        logic [14:0] size;
    } req_t;

    typedef struct {
        string          name;
        logic [63:0]    base;
        logic [31:0]    stride;
        int             width;
        int             height;
        int             n;
        logic [3:0][63:0] ea;
        logic [3:0]     es;
    } vec_t;

    logic                clk;
    logic                rst;
    logic                op_en;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [31:0]         cfg_line_stride;
    logic [WIDTH_W-1:0]  cfg_width;
    logic [HEIGHT_W-1:0] cfg_height;
    logic                pop;
    logic                op_busy;
    logic                op_done;
    logic [31:0]         perf_req_stall;
    logic [31:0]         perf_cdt_stall;

    nvdla_rubik_rd_req_gen_if #(.ADDR_W(ADDR_W)) dma ();

    nvdla_rubik_rd_req_gen #(
        .ADDR_W    (ADDR_W),
        .LAT_DEPTH (LAT),
        .WIDTH_W   (WIDTH_W),
        .HEIGHT_W  (HEIGHT_W)
    ) dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .op_en               (op_en),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_line_stride     (cfg_line_stride),
        .cfg_width           (cfg_width),
        .cfg_height          (cfg_height),
        .dma                 (dma),
        .rd_cdt_lat_fifo_pop (pop),
        .op_busy             (op_busy),
        .op_done             (op_done),
        .perf_req_stall      (perf_req_stall),
        .perf_cdt_stall      (perf_cdt_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          m_phase;   // 0 idle, 1 issuing, 2 waiting for credits, 3 done pulse
    int          m_cred;
    req_t        m_q[$];
    logic [31:0] m_preq;
    logic [31:0] m_pcdt;
    req_t        cap[$];
    int          dut_acc;
    bit          last_acc;
    bit [3:0]    hist;
    vec_t        tbl[NVEC];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected request list straight from the split rules: pairs only from 64B-aligned atoms.
    task automatic build_q(input logic [63:0] base, input logic [31:0] stride, input int w, input int h);
        m_q.delete();
        for (int l = 0; l <= h; l++) begin
            logic [63:0] a;
            int rem;
            a   = (base & ~64'h1F) + 64'(l) * {32'b0, stride & ~32'h1F};
            rem = w + 1;
            while (rem > 0) begin
                if (!a[5] && rem >= 2) begin
                    m_q.push_back('{addr: a, size: 15'd1});
                    a   = a + 64'd64;
                    rem = rem - 2;
                end else begin
                    m_q.push_back('{addr: a, size: 15'd0});
                    a   = a + 64'd32;
                    rem = rem - 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cred  = LAT;
        m_q.delete();
        m_preq  = 32'd0;
        m_pcdt  = 32'd0;
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input bit op, input bit rdy_i, input bit pop_i, input bit rst_i);
        bit ev;
        bit acc;
        int old_cred;
        op_en              = op;
        dma.dma_rd_req_rdy = rdy_i;
        pop                = pop_i;
        rst                = rst_i;
        #1;
        ev = (m_phase == 1) && (m_cred > 0);
        chk("vld", dma.dma_rd_req_vld, ev);
        if (ev) chk("pd", dma.dma_rd_req_pd, {m_q[0].size, m_q[0].addr});
        chk("busy", op_busy, m_phase != 0);
        chk("done", op_done, m_phase == 3);
        chk("perf_req", perf_req_stall, PERF_ON ? m_preq : 32'd0);
        chk("perf_cdt", perf_cdt_stall, PERF_ON ? m_pcdt : 32'd0);
        if (dma.dma_rd_req_vld && rdy_i) begin
            cap.push_back('{addr: dma.dma_rd_req_pd[63:0], size: dma.dma_rd_req_pd[78:64]});
            dut_acc++;
        end
        acc      = ev && rdy_i;
        last_acc = acc;
        if (rst_i) begin
            model_reset();
        end else begin
            old_cred = m_cred;
            if (m_phase == 1) begin
                if (ev && !rdy_i && m_preq != 32'hFFFF_FFFF) m_preq++;
                if (old_cred == 0 && m_pcdt != 32'hFFFF_FFFF) m_pcdt++;
            end
            m_cred = m_cred - int'(acc) + int'(pop_i);
            if (m_cred > LAT) m_cred = LAT;
            case (m_phase)
                0: if (op) begin
                    build_q(cfg_base_addr, cfg_line_stride, int'(cfg_width), int'(cfg_height));
                    m_phase = 1;
                    m_preq  = 32'd0;
                    m_pcdt  = 32'd0;
                end
                1: if (acc) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 2;
                end
                2: if (old_cred == LAT) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: rdy=1, each accept popped 4 cycles later. mode 1: random rdy/pop/stray op_en.
    task automatic finish_op(input int mode, input string nm);
        int budget;
        int dones;
        bit r;
        bit p;
        bit o;
        budget = 0;
        dones  = 0;
        while (m_phase != 0 && budget < BUDGET) begin
            if (mode == 0) begin
                r = 1'b1;
                p = hist[3];
                o = 1'b0;
            end else begin
                r = ($urandom_range(0, 3) != 0);
                p = (m_cred < LAT) && ($urandom_range(0, 1) == 1);
                o = ($urandom_range(0, 15) == 0);
            end
            if (op_done) dones++;
            cycle(o, r, p, 1'b0);
            if (mode == 0) hist = {hist[2:0], last_acc};
            budget++;
        end
        chk({nm, "_timeout"}, budget < BUDGET, 1);
        chk({nm, "_done_pulses"}, dones, 1);
    endtask

    task automatic set_cfg(input logic [63:0] b, input logic [31:0] s, input int w, input int h);
        cfg_base_addr   = b;
        cfg_line_stride = s;
        cfg_width       = WIDTH_W'(w);
        cfg_height      = HEIGHT_W'(h);
    endtask

    function automatic vec_t mk(input string nm, input logic [63:0] b, input logic [31:0] s,
                                input int w, input int h, input int n,
                                input logic [63:0] a0, input logic [63:0] a1,
                                input logic [63:0] a2, input logic [63:0] a3, input logic [3:0] es);
        vec_t v;
        v.name = nm; v.base = b; v.stride = s; v.width = w; v.height = h; v.n = n;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.es = es;
        return v;
    endfunction

    initial begin
        logic [95:0] pd0;
        logic [31:0] p1;
        n_chk = 0;
        n_err = 0;
        dut_acc = 0;
        hist = '0;
        op_en = 1'b0;
        pop = 1'b0;
        dma.dma_rd_req_rdy = 1'b0;
        rst = 1'b1;
        set_cfg(64'd0, 32'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_vld", dma.dma_rd_req_vld, 0);
        chk("rst_pd", dma.dma_rd_req_pd, 0);
        chk("rst_busy", op_busy, 0);
        chk("rst_done", op_done, 0);
        chk("rst_perf_req", perf_req_stall, 0);
        chk("rst_perf_cdt", perf_cdt_stall, 0);

        tbl[0] = mk("t1_aligned",  64'h1000, 32'h200, 3, 1, 4, 64'h1000, 64'h1040, 64'h1200, 64'h1240, 4'b1111);
        tbl[1] = mk("t2_unaligned", 64'h1020, 32'h200, 3, 0, 3, 64'h1020, 64'h1040, 64'h1080, 64'h0, 4'b0010);
        tbl[2] = mk("single_atoms", 64'h40, 32'h20, 0, 2, 3, 64'h40, 64'h60, 64'h80, 64'h0, 4'b0000);
        tbl[3] = mk("odd_tail", 64'h2000, 32'h100, 2, 0, 2, 64'h2000, 64'h2040, 64'h0, 64'h0, 4'b0001);
        tbl[4] = mk("addr_wrap", 64'hFFFF_FFFF_FFFF_FFC0, 32'h80, 1, 1, 2, 64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 64'h0, 64'h0, 4'b0011);
        tbl[5] = mk("low_bits", 64'h101F, 32'h40, 0, 1, 2, 64'h1000, 64'h1040, 64'h0, 64'h0, 4'b0000);

        for (int i = 0; i < NVEC; i++) begin
            set_cfg(tbl[i].base, tbl[i].stride, tbl[i].width, tbl[i].height);
            cap.delete();
            hist = '0;
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk({tbl[i].name, "_first_vld"}, dma.dma_rd_req_vld, 1);
            finish_op(0, tbl[i].name);
            chk({tbl[i].name, "_count"}, cap.size(), tbl[i].n);
            for (int j = 0; j < tbl[i].n; j++) begin
                if (j < cap.size()) begin
                    chk({tbl[i].name, "_addr"}, cap[j].addr, tbl[i].ea[j]);
                    chk({tbl[i].name, "_size"}, cap[j].size, {14'd0, tbl[i].es[j]});
                end
            end
        end

        // Credit exhaustion: no pops, so only LAT accepts; one pop releases one more.
        set_cfg(64'h0, 32'h0, 15, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        dut_acc = 0;
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_accepts_no_pop", dut_acc, LAT);
        chk("t3_vld_low", dma.dma_rd_req_vld, 0);
        chk("t3_cdt_stall_4", perf_cdt_stall, PERF_ON ? 32'd4 : 32'd0);
        p1 = perf_cdt_stall;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_accepts_after_pop", dut_acc, LAT + 1);
        chk("t3_cdt_stall_growth", perf_cdt_stall - p1, PERF_ON ? 32'd3 : 32'd0);
        finish_op(1, "t3");

        // Backpressure: pd must hold for 10 stalled cycles.
        set_cfg(64'h3000, 32'h0, 15, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        pd0 = 96'(dma.dma_rd_req_pd);
        chk("t4_pd0", pd0, {15'd1, 64'h3000});
        for (int k = 0; k < 10; k++) begin
            chk("t4_vld_held", dma.dma_rd_req_vld, 1);
            chk("t4_pd_stable", dma.dma_rd_req_pd, pd0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t4_req_stall", perf_req_stall, PERF_ON ? 32'd10 : 32'd0);
        finish_op(1, "t4");

        // Accept and pop together at credits==2 leaves two credits.
        set_cfg(64'h0, 32'h0, 15, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        dut_acc = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_accepts", dut_acc, 3);
        dut_acc = 0;
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_two_credits_left", dut_acc, 2);
        finish_op(1, "t5");

        // Reset mid-op, then restart from base with a full credit pool.
        set_cfg(64'h5000, 32'h400, 15, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t6_vld", dma.dma_rd_req_vld, 0);
        chk("t6_busy", op_busy, 0);
        chk("t6_done", op_done, 0);
        cap.delete();
        dut_acc = 0;
        hist = '0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_full_credits", dut_acc, LAT);
        if (cap.size() > 0) begin
            chk("t6_restart_addr", cap[0].addr, 64'h5000);
            chk("t6_restart_size", cap[0].size, 15'd1);
        end
        finish_op(1, "t6");

        // Randomized ops; cfg is scrambled after launch to confirm it was latched.
        for (int k = 0; k < 40; k++) begin
            logic [63:0] b;
            logic [31:0] s;
            b = {32'($urandom), 32'($urandom)};
            if (k % 5 == 0) b = 64'hFFFF_FFFF_FFFF_F000 | {52'd0, 12'($urandom)};
            s = (k % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 40)) * 32'd32;
            set_cfg(b, s, $urandom_range(0, 9), $urandom_range(0, 3));
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            set_cfg({32'($urandom), 32'($urandom)}, 32'($urandom), $urandom_range(0, 9), $urandom_range(0, 3));
            finish_op(1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
